// File: rtl/bram_pkg.sv
// Shared defaults for the block-RAM family (single- and dual-port variants).
// Sized so a default instance is 16 words of 8 bits.
package bram_pkg;

   localparam int BRAM_DATA_WIDTH = 8;
   localparam int BRAM_ADDR_WIDTH = 4;

endpackage

// File: rtl/single_port_bram.sv
// Single-clock block RAM: one write port and one registered read port.
// Reads are read-first; reset clears only the output register, never the array.
module single_port_bram
   import bram_pkg::*;
#(
   parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH
) (
   input  logic                  i_CLK,
   input  logic                  i_RESET,
   input  logic                  i_WRITE_ENABLE,
   input  logic [ADDR_WIDTH-1:0] i_WRITE_ADDRESS,
   input  logic [DATA_WIDTH-1:0] i_WRITE_DATA,
   input  logic                  i_READ_ENABLE,
   input  logic [ADDR_WIDTH-1:0] i_READ_ADDRESS,
   output logic [DATA_WIDTH-1:0] o_READ_DATA
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] read_data_d;
   logic [DATA_WIDTH-1:0] read_data_q;

   // No reset on the array so it maps onto block RAM; writes are gated by reset.
   always_ff @(posedge i_CLK) begin
      if (i_WRITE_ENABLE && !i_RESET) begin
         mem[i_WRITE_ADDRESS] <= i_WRITE_DATA;
      end
   end

   always_comb begin
      read_data_d = read_data_q;
      if (i_READ_ENABLE) begin
         read_data_d = mem[i_READ_ADDRESS];
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         read_data_q <= '0;
      end else begin
         read_data_q <= read_data_d;
      end
   end

   assign o_READ_DATA = read_data_q;

`ifdef FORMAL
   logic past_valid_q;

   always_ff @(posedge i_CLK) begin
      past_valid_q <= 1'b1;
      if (past_valid_q && $past(i_RESET)) begin
         assert (o_READ_DATA == '0);
      end
      if (past_valid_q && !$past(i_RESET) && !$past(i_READ_ENABLE)) begin
         assert (o_READ_DATA == $past(o_READ_DATA));
      end
   end
`endif

endmodule

// File: tb/tb_single_port_bram.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural array model.
module tb_single_port_bram;

   logic       clk;
   logic       rst;
   logic       we;
   logic [3:0] wa;
   logic [7:0] wd;
   logic       re;
   logic [3:0] ra;
   logic [7:0] rd;

   int checks = 0;
   int errors = 0;

   single_port_bram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .i_CLK          (clk),
      .i_RESET        (rst),
      .i_WRITE_ENABLE (we),
      .i_WRITE_ADDRESS(wa),
      .i_WRITE_DATA   (wd),
      .i_READ_ENABLE  (re),
      .i_READ_ADDRESS (ra),
      .o_READ_DATA    (rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: plain array plus "known" flags, since power-up
   // contents and the pre-reset output are undefined.
   logic [7:0] mdl_mem [16];
   bit         mdl_known [16];
   logic [7:0] mdl_rd = 8'h00;
   bit         mdl_rd_known = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         mdl_rd       = 8'h00;
         mdl_rd_known = 1'b1;
      end else begin
         if (re) begin
            mdl_rd       = mdl_mem[ra];
            mdl_rd_known = mdl_known[ra];
         end
         if (we) begin
            mdl_mem[wa]   = wd;
            mdl_known[wa] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (mdl_rd_known) begin
         checks++;
         if (rd !== mdl_rd) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%02h expected=%02h", $time, rd, mdl_rd);
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%02h expected=%02h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then return on the following falling edge.
   task automatic cyc(input bit r, input bit w, input logic [3:0] a_w, input logic [7:0] d_w,
                      input bit e, input logic [3:0] a_r);
      rst = r; we = w; wa = a_w; wd = d_w; re = e; ra = a_r;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; re = 1'b0; ra = '0;
      @(negedge clk);
      cyc(1, 0, 0, 8'h00, 1, 0);
      check("reset_out", rd, 8'h00);

      // write then read with one-edge latency
      cyc(0, 1, 4'h0, 8'h2A, 0, 0);
      cyc(0, 0, 0, 8'h00, 1, 4'h0);
      check("wr_rd_0", rd, 8'h2A);
      check("model_pin_0", mdl_rd, 8'h2A);

      // output holds while read disabled, even if the address moves
      cyc(0, 1, 4'h3, 8'hFE, 0, 0);
      cyc(0, 1, 4'h8, 8'h2E, 0, 0);
      cyc(0, 0, 0, 8'h00, 1, 4'h3);
      check("rd_3", rd, 8'hFE);
      cyc(0, 0, 0, 8'h00, 0, 4'h8);
      check("hold_no_re", rd, 8'hFE);
      cyc(0, 0, 0, 8'h00, 1, 4'h8);
      check("rd_8", rd, 8'h2E);

      // same-address read/write is read-first
      cyc(0, 1, 4'h5, 8'h11, 0, 0);
      cyc(0, 1, 4'h5, 8'h77, 1, 4'h5);
      check("read_first_old", rd, 8'h11);
      check("model_pin_rf", mdl_rd, 8'h11);
      cyc(0, 0, 0, 8'h00, 1, 4'h5);
      check("read_first_new", rd, 8'h77);

      // both ends of the address range, no aliasing
      cyc(0, 1, 4'hF, 8'hA5, 0, 0);
      cyc(0, 1, 4'h0, 8'h5A, 1, 4'hF);
      check("rd_top", rd, 8'hA5);
      cyc(0, 0, 0, 8'h00, 1, 4'h0);
      check("rd_bottom", rd, 8'h5A);

      // reset clears output but not memory
      cyc(0, 1, 4'h0, 8'h2A, 0, 0);
      cyc(0, 0, 0, 8'h00, 1, 4'h0);
      check("pre_reset", rd, 8'h2A);
      cyc(1, 0, 0, 8'h00, 1, 4'h0);
      check("reset_clear", rd, 8'h00);
      cyc(0, 0, 0, 8'h00, 1, 4'h0);
      check("retained", rd, 8'h2A);

      // write during reset is ignored
      cyc(0, 1, 4'h2, 8'h33, 0, 0);
      cyc(1, 1, 4'h2, 8'hFF, 0, 0);
      check("reset_clear2", rd, 8'h00);
      cyc(0, 0, 0, 8'h00, 1, 4'h2);
      check("wr_in_reset_ignored", rd, 8'h33);
      check("model_pin_rst_wr", mdl_rd, 8'h33);

      // randomized traffic, checked by the per-cycle model compare
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 24) == 0),
             1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)),
             1'($urandom_range(0, 2) != 0),
             4'($urandom_range(0, 15)));
      end

      // sweep every address once to confirm full range
      for (int a = 0; a < 16; a++) cyc(0, 1, 4'(a), 8'(8'hC0 ^ a), 0, 0);
      for (int a = 0; a < 16; a++) begin
         cyc(0, 0, 0, 8'h00, 1, 4'(a));
         check("sweep", rd, 8'(8'hC0 ^ a));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end

endmodule
